bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner.sv | 184 ++++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - binary to BCD converter driving a multiplexed active-low 7-segment display
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module bcd_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [15:0] MAX_VALUE = 16'd9999;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state, state_n;
  logic [15:0] src, src_n;
  logic [15:0] scratch, scratch_n;
  logic [15:0] last_value, last_value_n;
  logic [15:0] bcd_n;
  logic [15:0] adj;
  logic [3:0]  cnt, cnt_n;
  logic        first_flag, first_flag_n;
  logic        ovf_sel, ovf_sel_n;
  logic        ovf_n;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic [6:0]       seg_n;

  assign busy = (state != IDLE);

  // Shift-add-3 correction applied before each shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n      = state;
    src_n        = src;
    scratch_n    = scratch;
    last_value_n = last_value;
    cnt_n        = cnt;
    first_flag_n = first_flag;
    ovf_sel_n    = ovf_sel;
    bcd_n        = bcd;
    ovf_n        = ovf;
    case (state)
      IDLE: begin
        if (first_flag || (value != last_value)) begin
          src_n        = value;
          last_value_n = value;
          if (value > MAX_VALUE) begin
            ovf_sel_n = 1'b1;
            state_n   = LOAD;
          end else begin
            ovf_sel_n = 1'b0;
            scratch_n = '0;
            cnt_n     = '0;
            state_n   = SHIFT;
          end
        end
      end
      SHIFT: begin
        {scratch_n, src_n} = {adj, src} << 1;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd15)
          state_n = LOAD;
      end
      LOAD: begin
        bcd_n        = ovf_sel ? 16'h9999 : scratch;
        ovf_n        = ovf_sel;
        first_flag_n = 1'b0;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src        <= '0;
      scratch    <= '0;
      last_value <= '0;
      cnt        <= '0;
      first_flag <= 1'b1;
      ovf_sel    <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      src        <= src_n;
      scratch    <= scratch_n;
      last_value <= last_value_n;
      cnt        <= cnt_n;
      first_flag <= first_flag_n;
      ovf_sel    <= ovf_sel_n;
      bcd        <= bcd_n;
      ovf        <= ovf_n;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign digit = bcd[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:1] lead_zero;
  logic       blank;

  always_comb begin
    lead_zero[3] = (bcd[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (bcd[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (bcd[7:4] == 4'd0);
    case (idx)
      2'd1:    blank = lead_zero[1];
      2'd2:    blank = lead_zero[2];
      2'd3:    blank = lead_zero[3];
      default: blank = 1'b0;
    endcase
  end
`endif

  // ovf overrides both the digit pattern and any blanking
  always_comb begin
    seg_n = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (blank)
      seg_n = 7'h7F;
`endif
    if (ovf)
      seg_n = 7'h3F;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= 2'd0;
      seg <= 7'h7F;
      an  <= 4'hF;
    end else begin
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      seg <= seg_n;
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic [15:0] bcd;
  logic        ovf;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;
  int model_value = 0;
  int edges = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pw [4] = '{1, 10, 100, 1000};

  bcd_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd),
    .ovf(ovf), .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the expected scan position
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] to_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int pos_of(input int e);
    return ((e - 1) / SCAN_DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int e);
    if (e == 0) return 4'hF;
    return ~(4'b0001 << pos_of(e));
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int k);
    if (v > 9999) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && v < pw[k]) return 7'h7F;
`endif
    return seg_tab[(v / pw[k]) % 10];
  endfunction

  // Drive a value and measure busy length; no checking here
  task automatic run_conversion(input logic [15:0] v, output bit busy0, output int lat);
    @(negedge clk);
    value = v;
    @(posedge clk);
    @(negedge clk);
    busy0 = busy;
    lat = 0;
    while (busy && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    model_value = int'(v);
  endtask

  task automatic test_reset;
    int lat;
    reset = 1'b1;
    value = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if (bcd !== 16'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL release_busy got=%b exp=1", busy); end
    lat = 0;
    while (busy && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    model_value = 0;
    checks++; if (lat != 17) begin failures++; $display("FAIL release_latency got=%0d exp=17", lat); end
    checks++; if (bcd !== to_bcd(0) || ovf !== 1'b0) begin
      failures++; $display("FAIL release_result got=%h/%b exp=%h/0", bcd, ovf, to_bcd(0));
    end
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(edges) || seg !== exp_seg(model_value, pos_of(edges))) begin
        failures++;
        $display("FAIL zero_scan got=%h/%h exp=%h/%h", an, seg, exp_an(edges), exp_seg(model_value, pos_of(edges)));
      end
    end
  endtask

  task automatic test_scan;
    bit b0;
    int lat;
    run_conversion(16'd1234, b0, lat);
    checks++; if (!b0 || lat != 17) begin failures++; $display("FAIL scan_latency got=%b/%0d exp=1/17", b0, lat); end
    checks++; if (bcd !== 16'h1234 || ovf !== 1'b0) begin failures++; $display("FAIL scan_bcd got=%h/%b exp=1234/0", bcd, ovf); end
    @(negedge clk);
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(edges) || seg !== exp_seg(model_value, pos_of(edges))) begin
        failures++;
        $display("FAIL scan_1234 got=%h/%h exp=%h/%h", an, seg, exp_an(edges), exp_seg(model_value, pos_of(edges)));
      end
    end
  endtask

  task automatic test_wrap;
    bit b0;
    int lat;
    run_conversion(16'd9999, b0, lat);
    checks++; if (lat != 17 || bcd !== 16'h9999 || ovf !== 1'b0) begin
      failures++; $display("FAIL wrap_9999 got=%0d/%h/%b exp=17/9999/0", lat, bcd, ovf);
    end
    run_conversion(16'd0, b0, lat);
    checks++; if (lat != 17 || bcd !== 16'h0000 || ovf !== 1'b0) begin
      failures++; $display("FAIL wrap_0 got=%0d/%h/%b exp=17/0000/0", lat, bcd, ovf);
    end
  endtask

  task automatic test_ovf;
    bit b0;
    int lat;
    run_conversion(16'd10000, b0, lat);
    checks++; if (!b0 || lat != 1) begin failures++; $display("FAIL ovf_latency got=%b/%0d exp=1/1", b0, lat); end
    checks++; if (bcd !== 16'h9999 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_result got=%h/%b exp=9999/1", bcd, ovf); end
    @(negedge clk);
    for (int i = 0; i < 2 * SCAN_DIV + 1; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(edges) || seg !== 7'h3F) begin
        failures++; $display("FAIL ovf_scan got=%h/%h exp=%h/3f", an, seg, exp_an(edges));
      end
    end
    run_conversion(16'd42, b0, lat);
    checks++; if (lat != 17 || bcd !== 16'h0042 || ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%0d/%h/%b exp=17/0042/0", lat, bcd, ovf);
    end
  endtask

  task automatic test_same_value;
    bit seen_busy = 0;
    @(negedge clk);
    value = 16'(model_value);
    repeat (4) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    checks++; if (seen_busy) begin failures++; $display("FAIL same_value_busy got=1 exp=0"); end
  endtask

  task automatic test_back_to_back;
    bit saw5 = 0, saw6 = 0;
    @(negedge clk);
    value = 16'd5;
    @(negedge clk);
    value = 16'd6;
    @(negedge clk);
    value = 16'd7;
    model_value = 7;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bcd === 16'h0005) saw5 = 1;
      if (bcd === 16'h0006) saw6 = 1;
    end
    checks++; if (!saw5) begin failures++; $display("FAIL b2b_first got=0 exp=1 (bcd 0005 seen)"); end
    checks++; if (saw6) begin failures++; $display("FAIL b2b_dropped got=1 exp=0 (bcd 0006 seen)"); end
    checks++; if (bcd !== 16'h0007 || busy !== 1'b0) begin failures++; $display("FAIL b2b_final got=%h/%b exp=0007/0", bcd, busy); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    value = 16'd4321;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || bcd !== 16'h0007) begin
      failures++; $display("FAIL mid_hold got=%b/%h exp=1/0007", busy, bcd);
    end
    reset = 1'b1;
    #1;
    checks++; if (bcd !== 16'h0 || ovf !== 1'b0 || busy !== 1'b0 || seg !== 7'h7F || an !== 4'hF) begin
      failures++; $display("FAIL mid_reset got=%h/%b/%b/%h/%h exp=0000/0/0/7f/f", bcd, ovf, busy, seg, an);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    lat = 0;
    while (busy && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    model_value = 4321;
    checks++; if (lat != 17 || bcd !== 16'h4321) begin
      failures++; $display("FAIL mid_restart got=%0d/%h exp=17/4321", lat, bcd);
    end
  endtask

  task automatic test_random;
    bit b0;
    int lat;
    int v;
    for (int n = 0; n < 12; n++) begin
      v = int'($urandom_range(0, 11999));
      if (v == model_value) v = (v + 1) % 12000;
      run_conversion(16'(v), b0, lat);
      checks++;
      if (!b0 || lat != (v > 9999 ? 1 : 17) || bcd !== to_bcd(v) || ovf !== (v > 9999)) begin
        failures++;
        $display("FAIL random_conv v=%0d got=%b/%0d/%h/%b exp=1/%0d/%h/%b", v, b0, lat, bcd, ovf,
                 (v > 9999 ? 1 : 17), to_bcd(v), (v > 9999));
      end
      @(negedge clk);
      for (int i = 0; i < SCAN_DIV + 1; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an(edges) || seg !== exp_seg(v, pos_of(edges))) begin
          failures++;
          $display("FAIL random_scan v=%0d got=%h/%h exp=%h/%h", v, an, seg, exp_an(edges), exp_seg(v, pos_of(edges)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_wrap();
    test_ovf();
    test_same_value();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
